// File: rtl/neo_pkg.sv
// Shared types, default timing and sizing helpers for the NeoPixel transmitter family.
package neo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_LATCH = 3'd4
    } neo_state_e;

    localparam int DEF_PIX_W     = 24;
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_FIFO_AW   = 10;
    localparam int DEF_T0H_CYC   = 8;
    localparam int DEF_T1H_CYC   = 16;
    localparam int DEF_TBIT_CYC  = 25;
    localparam int DEF_LATCH_CYC = 1000;

    function automatic int ch_width(input int num_ch);
        int w;
        if (num_ch > 32'sd1) w = $clog2(num_ch);
        else                 w = 32'sd1;
        return w;
    endfunction

    function automatic int cnt_width(input int tbit_cyc, input int latch_cyc);
        int m;
        m = (32'sd2 * tbit_cyc > latch_cyc) ? (32'sd2 * tbit_cyc) : latch_cyc;
        return $clog2(m + 32'sd1);
    endfunction

    // 400k mode doubles every bit-level interval; the latch time is not scaled.
    function automatic int scale_cyc(input int cyc, input logic mode);
        return mode ? (cyc * 32'sd2) : cyc;
    endfunction

endpackage

// File: rtl/neopixel_multi_tx_if.sv
// Host write port of the NeoPixel transmitter: push strobe, tagged pixel word and FIFO status.
interface neopixel_multi_tx_if #(
    parameter int DIN_W = 27
);
    logic             wr_en;
    logic [DIN_W-1:0] din;
    logic             full_flg;
    logic             empty_flg;

    modport master (output wr_en, output din, input full_flg, input empty_flg);
    modport slave  (input wr_en, input din, output full_flg, output empty_flg);
endinterface

// File: rtl/neo_sync_fifo.sv
// Single-clock FIFO with registered read data (1-cycle latency) and registered full/empty flags.
module neo_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_nx_s;
    logic [W-1:0]  rd_data_r;
    logic          full_r, empty_r;
    logic          do_wr_s, do_rd_s;

    // A write while full is accepted only when a read frees a slot in the same cycle.
    assign do_rd_s = rd_en & ~empty_r;
    assign do_wr_s = wr_en & (~full_r | do_rd_s);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nx_s = count_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_nx_s = count_r + (AW + 1)'(1);
            2'b01:   count_nx_s = count_r - (AW + 1)'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Storage array; not reset, contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, registered read data and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= AW'(0);
            rd_ptr_r  <= AW'(0);
            count_r   <= (AW + 1)'(0);
            rd_data_r <= W'(0);
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == (AW + 1)'(DEPTH));
            empty_r <= (count_nx_s == (AW + 1)'(0));
        end
    end

    assign rd_data = rd_data_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/neopixel_multi_tx.sv
// Time-multiplexed WS281x transmitter: pixel FIFO, bit-timing FSM, channel demux and sticky flags.
// Defining NEO_TX_STATS_EN adds the frame_cnt / pix_cnt statistics outputs.
module neopixel_multi_tx
    import neo_pkg::*;
#(
    parameter int PIX_W     = DEF_PIX_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int FIFO_AW   = DEF_FIFO_AW,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int TBIT_CYC  = DEF_TBIT_CYC,
    parameter int LATCH_CYC = DEF_LATCH_CYC
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               tx_enable,
    input  logic               mode,
    neopixel_multi_tx_if.slave wr_if,
    output logic               busy,
    output logic               ovf_flg,
    output logic               udr_flg,
    input  logic               clr_flg,
    output logic [NUM_CH-1:0]  neo_tx_out
`ifdef NEO_TX_STATS_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [31:0]        pix_cnt
`endif
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int DIN_W = PIX_W + CH_W + 1;
    localparam int CNT_W = cnt_width(TBIT_CYC, LATCH_CYC);
    localparam int BIT_W = $clog2(PIX_W);

    neo_state_e        state_r, state_nx_s;
    logic [CNT_W-1:0]  cyc_r, th_s, tbit_s, tl_s;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [PIX_W-1:0]  shift_r;
    logic [CH_W-1:0]   ch_r, ch_nx_s;
    logic [NUM_CH-1:0] tx_r, tx_nx_s;
    logic              mode_r, last_r, new_frame_r, busy_r, ovf_r, udr_r;
    logic              rd_en_s, load_s, shift_s, cyc_clr_s, udr_set_s, ovf_set_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [DIN_W-1:0]  fifo_q_s;
    logic              q_last_s;
    logic [CH_W-1:0]   q_ch_s;
    logic [PIX_W-1:0]  q_pix_s;

    neo_sync_fifo #(
        .W  (DIN_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (sys_rst),
        .wr_en   (wr_if.wr_en),
        .wr_data (wr_if.din),
        .rd_en   (rd_en_s),
        .rd_data (fifo_q_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign wr_if.full_flg  = fifo_full_s;
    assign wr_if.empty_flg = fifo_empty_s;

    assign q_last_s = fifo_q_s[DIN_W-1];
    assign q_ch_s   = fifo_q_s[PIX_W +: CH_W];
    assign q_pix_s  = fifo_q_s[PIX_W-1:0];

    // High time follows the bit currently at the MSB; all intervals use the frame's latched mode.
    assign th_s   = CNT_W'(scale_cyc(shift_r[PIX_W-1] ? T1H_CYC : T0H_CYC, mode_r));
    assign tbit_s = CNT_W'(scale_cyc(TBIT_CYC, mode_r));
    assign tl_s   = tbit_s - th_s;

    assign ovf_set_s = wr_if.wr_en & fifo_full_s & ~rd_en_s;

    // Next-state and control decode.
    always_comb begin
        state_nx_s = state_r;
        rd_en_s    = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        cyc_clr_s  = 1'b0;
        udr_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cyc_clr_s = 1'b1;
                if (tx_enable && !fifo_empty_s) begin
                    rd_en_s    = 1'b1;
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s     = 1'b1;
                cyc_clr_s  = 1'b1;
                state_nx_s = ST_HIGH;
            end
            ST_HIGH: begin
                if (cyc_r == th_s - CNT_W'(1)) begin
                    cyc_clr_s  = 1'b1;
                    state_nx_s = ST_LOW;
                end else begin
                    state_nx_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (bit_cnt_r != BIT_W'(0)) begin
                    if (cyc_r == tl_s - CNT_W'(1)) begin
                        shift_s    = 1'b1;
                        cyc_clr_s  = 1'b1;
                        state_nx_s = ST_HIGH;
                    end else begin
                        state_nx_s = ST_LOW;
                    end
                // Pop two cycles early so the LOAD cycle fills the last low slot of the pixel.
                end else if ((cyc_r == tl_s - CNT_W'(2)) && !last_r && tx_enable && !fifo_empty_s) begin
                    rd_en_s    = 1'b1;
                    state_nx_s = ST_LOAD;
                end else if (cyc_r == tl_s - CNT_W'(1)) begin
                    udr_set_s  = !last_r && tx_enable && fifo_empty_s;
                    cyc_clr_s  = 1'b1;
                    state_nx_s = ST_LATCH;
                end else begin
                    state_nx_s = ST_LOW;
                end
            end
            ST_LATCH: begin
                if (cyc_r == CNT_W'(LATCH_CYC - 1)) begin
                    cyc_clr_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LATCH;
                end
            end
            default: begin
                cyc_clr_s  = 1'b1;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Channel demux computed from next state so the line register tracks the FSM cycle-exactly.
    always_comb begin
        ch_nx_s = ch_r;
        tx_nx_s = {NUM_CH{1'b0}};
        if (load_s && new_frame_r) begin
            ch_nx_s = q_ch_s;
        end else begin
            ch_nx_s = ch_r;
        end
        if (state_nx_s == ST_HIGH) begin
            tx_nx_s = NUM_CH'(1) << ch_nx_s;
        end else begin
            tx_nx_s = {NUM_CH{1'b0}};
        end
    end

    // FSM state, counters, shift register, line outputs and sticky flags.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r     <= ST_IDLE;
            cyc_r       <= CNT_W'(0);
            bit_cnt_r   <= BIT_W'(0);
            shift_r     <= PIX_W'(0);
            ch_r        <= CH_W'(0);
            mode_r      <= 1'b0;
            last_r      <= 1'b0;
            new_frame_r <= 1'b0;
            busy_r      <= 1'b0;
            tx_r        <= {NUM_CH{1'b0}};
            ovf_r       <= 1'b0;
            udr_r       <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            tx_r    <= tx_nx_s;
            ch_r    <= ch_nx_s;
            cyc_r   <= cyc_clr_s ? CNT_W'(0) : (cyc_r + CNT_W'(1));
            if ((state_r == ST_IDLE) && rd_en_s) begin
                mode_r      <= mode;
                new_frame_r <= 1'b1;
            end
            if (load_s) begin
                shift_r     <= q_pix_s;
                bit_cnt_r   <= BIT_W'(PIX_W - 1);
                last_r      <= q_last_s;
                new_frame_r <= 1'b0;
            end else if (shift_s) begin
                shift_r   <= shift_r << 1;
                bit_cnt_r <= bit_cnt_r - BIT_W'(1);
            end
            if (ovf_set_s)    ovf_r <= 1'b1;
            else if (clr_flg) ovf_r <= 1'b0;
            if (udr_set_s)    udr_r <= 1'b1;
            else if (clr_flg) udr_r <= 1'b0;
        end
    end

    assign busy       = busy_r;
    assign ovf_flg    = ovf_r;
    assign udr_flg    = udr_r;
    assign neo_tx_out = tx_r;

`ifdef NEO_TX_STATS_EN
    logic [15:0] frame_cnt_r;
    logic [31:0] pix_cnt_r;
    logic        frame_done_s, pix_done_s;

    assign frame_done_s = (state_r == ST_LATCH) && (state_nx_s == ST_IDLE);
    assign pix_done_s   = (state_r == ST_LOW) && (bit_cnt_r == BIT_W'(0)) && (state_nx_s != ST_LOW);

    // Free-running statistics; wrap naturally and ignore clr_flg.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            frame_cnt_r <= 16'd0;
            pix_cnt_r   <= 32'd0;
        end else begin
            if (frame_done_s) frame_cnt_r <= frame_cnt_r + 16'd1;
            if (pix_done_s)   pix_cnt_r   <= pix_cnt_r + 32'd1;
        end
    end

    assign frame_cnt = frame_cnt_r;
    assign pix_cnt   = pix_cnt_r;
`endif

endmodule

// File: tb/tb_neopixel_multi_tx.sv
// Self-checking bench for neopixel_multi_tx: randomized pixel words checked against a frame-level model.
module tb_neopixel_multi_tx;

    localparam int PIX_W   = 24;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;
    localparam int DIN_W   = PIX_W + CH_W + 1;
    localparam int T0H     = 8;
    localparam int T1H     = 16;
    localparam int TBIT    = 25;
    localparam int LATCH   = 1000;

    logic clk = 1'b0;
    logic sys_rst, tx_enable, mode, clr_flg;
    logic busy, ovf_flg, udr_flg;
    logic [NUM_CH-1:0] neo;
`ifdef NEO_TX_STATS_EN
    logic [15:0] frame_cnt;
    logic [31:0] pix_cnt;
`endif

    neopixel_multi_tx_if #(.DIN_W(DIN_W)) wr_if ();

    neopixel_multi_tx #(
        .PIX_W(PIX_W), .NUM_CH(NUM_CH), .FIFO_AW(FIFO_AW), .T0H_CYC(T0H),
        .T1H_CYC(T1H), .TBIT_CYC(TBIT), .LATCH_CYC(LATCH)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .tx_enable(tx_enable), .mode(mode),
        .wr_if(wr_if), .busy(busy), .ovf_flg(ovf_flg), .udr_flg(udr_flg),
        .clr_flg(clr_flg), .neo_tx_out(neo)
`ifdef NEO_TX_STATS_EN
        , .frame_cnt(frame_cnt), .pix_cnt(pix_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [DIN_W-1:0] mq[$];
    logic ovf_exp = 1'b0;
    int frame_exp = 0;
    int pix_exp = 0;

    // pulse monitor
    int cyc = 0;
    int rise_cyc[NUM_CH];
    logic [NUM_CH-1:0] prev = '0;
    logic busy_prev = 1'b0;
    int busy_fall = -1;
    int pq_ch[$];
    int pq_start[$];
    int pq_len[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (neo[c] && !prev[c]) rise_cyc[c] = cyc;
            if (!neo[c] && prev[c]) begin
                pq_ch.push_back(c);
                pq_start.push_back(rise_cyc[c]);
                pq_len.push_back(cyc - rise_cyc[c]);
            end
        end
        if (!busy && busy_prev) busy_fall = cyc;
        prev = neo;
        busy_prev = busy;
    end

    function automatic logic [DIN_W-1:0] mkword(input logic last, input int ch, input logic [PIX_W-1:0] pix);
        logic [CH_W-1:0] c;
        c = CH_W'(ch);
        return {last, c, pix};
    endfunction

    task automatic push_word(input logic [DIN_W-1:0] w);
        @(negedge clk);
        wr_if.wr_en = 1'b1;
        wr_if.din = w;
        @(negedge clk);
        wr_if.wr_en = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(w);
        else ovf_exp = 1'b1;
    endtask

    task automatic check_stats();
`ifdef NEO_TX_STATS_EN
        vectors++;
        if (frame_cnt !== 16'(frame_exp) || pix_cnt !== 32'(pix_exp)) begin
            miscompares++;
            $display("FAIL stats: frame_cnt=%0d pix_cnt=%0d required %0d/%0d", frame_cnt, pix_cnt, frame_exp, pix_exp);
        end
`endif
    endtask

    // Runs one frame from the current FIFO contents and checks it against the model.
    task automatic run_frame(input logic md, input logic flip, input logic drop);
        int s, npix, ch_exp, t_end, lat_exp, last_i;
        logic udr_e, done, started, finished;
        logic [DIN_W-1:0] w;
        int exp_len[$];
        s = md ? 2 : 1;
        npix = 0;
        udr_e = 1'b0;
        done = 1'b0;
        w = mq[0];
        ch_exp = int'(w[PIX_W +: CH_W]);
        while (!done) begin
            w = mq.pop_front();
            npix++;
            for (int b = PIX_W - 1; b >= 0; b--) exp_len.push_back((w[b] ? T1H : T0H) * s);
            if (drop || w[DIN_W-1]) done = 1'b1;
            else if (mq.size() == 0) begin
                done = 1'b1;
                udr_e = 1'b1;
            end
        end
        frame_exp++;
        pix_exp += npix;

        pq_ch.delete(); pq_start.delete(); pq_len.delete();
        busy_fall = -1;
        @(negedge clk);
        mode = md;
        tx_enable = 1'b1;
        started = 1'b0;
        for (int i = 0; i < 10 && !started; i++) begin
            @(negedge clk);
            if (busy) started = 1'b1;
        end
        vectors++;
        if (!started) begin
            miscompares++;
            $display("FAIL frame_start: busy=%b required 1 within 10 cycles", busy);
        end
        if (flip) mode = ~md;
        if (drop) begin
            repeat (30) @(negedge clk);
            tx_enable = 1'b0;
        end
        finished = 1'b0;
        for (int i = 0; i < 8000 && !finished; i++) begin
            @(negedge clk);
            if (!busy) begin
                finished = 1'b1;
                tx_enable = 1'b0;
            end
        end
        tx_enable = 1'b0;
        mode = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL frame_end: busy=%b required 0 within 8000 cycles", busy);
        end
        repeat (2) @(negedge clk);

        vectors++;
        if (pq_len.size() != exp_len.size()) begin
            miscompares++;
            $display("FAIL pulse_count: got %0d pulses, required %0d", pq_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < pq_len.size(); i++) begin
            vectors++;
            if (pq_ch[i] != ch_exp || pq_len[i] != exp_len[i]) begin
                miscompares++;
                $display("FAIL bit%0d: ch=%0d high=%0d, required ch=%0d high=%0d", i, pq_ch[i], pq_len[i], ch_exp, exp_len[i]);
            end
            if (i > 0) begin
                vectors++;
                if (pq_start[i] - pq_start[i-1] != TBIT * s) begin
                    miscompares++;
                    $display("FAIL period%0d: got %0d, required %0d", i, pq_start[i] - pq_start[i-1], TBIT * s);
                end
            end
        end
        if (pq_len.size() > 0 && pq_len.size() == exp_len.size()) begin
            last_i = pq_len.size() - 1;
            t_end = pq_start[last_i] + pq_len[last_i];
            lat_exp = TBIT * s - exp_len[last_i] + LATCH;
            vectors++;
            if (busy_fall - t_end != lat_exp) begin
                miscompares++;
                $display("FAIL latch: low before idle %0d cycles, required %0d", busy_fall - t_end, lat_exp);
            end
        end

        vectors++;
        if (udr_flg !== udr_e) begin
            miscompares++;
            $display("FAIL udr_flg: got %b, required %b", udr_flg, udr_e);
        end
        vectors++;
        if (ovf_flg !== ovf_exp) begin
            miscompares++;
            $display("FAIL ovf_flg: got %b, required %b", ovf_flg, ovf_exp);
        end
        vectors++;
        if (wr_if.empty_flg !== (mq.size() == 0)) begin
            miscompares++;
            $display("FAIL empty_flg: got %b, required %b", wr_if.empty_flg, (mq.size() == 0));
        end
        check_stats();
        if (udr_e || ovf_exp) begin
            @(negedge clk); clr_flg = 1'b1;
            @(negedge clk); clr_flg = 1'b0;
            ovf_exp = 1'b0;
            vectors++;
            if (udr_flg !== 1'b0 || ovf_flg !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_flg: udr=%b ovf=%b, required 0/0", udr_flg, ovf_flg);
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; tx_enable = 1'b0; mode = 1'b0; clr_flg = 1'b0;
        wr_if.wr_en = 1'b0; wr_if.din = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (neo !== 4'b0000 || busy !== 1'b0 || ovf_flg !== 1'b0 || udr_flg !== 1'b0 ||
            wr_if.full_flg !== 1'b0 || wr_if.empty_flg !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: neo=%b busy=%b ovf=%b udr=%b full=%b empty=%b, required 0000/0/0/0/0/1",
                     neo, busy, ovf_flg, udr_flg, wr_if.full_flg, wr_if.empty_flg);
        end
        check_stats();
        sys_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_800k();
        push_word(mkword(1'b1, 0, 24'h800001));
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_400k();
        push_word(mkword(1'b1, 0, 24'h800001));
        run_frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_multi_channel();
        push_word(mkword(1'b0, 2, 24'($urandom)));
        push_word(mkword(1'b1, 2, 24'($urandom)));
        run_frame(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_underrun();
        push_word(mkword(1'b0, 1, 24'($urandom)));
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            push_word(mkword(i == 3, int'($urandom_range(0, 3)), 24'($urandom)));
            if (i == 3) begin
                vectors++;
                if (wr_if.full_flg !== 1'b1 || ovf_flg !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_after_4: full=%b ovf=%b, required 1/0", wr_if.full_flg, ovf_flg);
                end
            end
        end
        vectors++;
        if (ovf_flg !== ovf_exp) begin
            miscompares++;
            $display("FAIL ovf_after_5: ovf=%b, required %b", ovf_flg, ovf_exp);
        end
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_enable_drop();
        push_word(mkword(1'b0, 3, 24'($urandom)));
        push_word(mkword(1'b1, 3, 24'($urandom)));
        run_frame(1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                push_word(mkword($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), 24'($urandom)));
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_reset_mid_bit();
        logic started;
        push_word(mkword(1'b1, 1, 24'hFFFFFF));
        push_word(mkword(1'b1, 2, 24'h123456));
        @(negedge clk);
        tx_enable = 1'b1;
        started = 1'b0;
        for (int i = 0; i < 10 && !started; i++) begin
            @(negedge clk);
            if (busy) started = 1'b1;
        end
        repeat (40) @(negedge clk);
        @(posedge clk);
        #3;
        sys_rst = 1'b0;
        #1;
        mq.delete();
        ovf_exp = 1'b0;
        frame_exp = 0;
        pix_exp = 0;
        vectors++;
        if (!started || neo !== 4'b0000 || busy !== 1'b0 || wr_if.empty_flg !== 1'b1 ||
            wr_if.full_flg !== 1'b0 || ovf_flg !== 1'b0 || udr_flg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: started=%b neo=%b busy=%b empty=%b full=%b ovf=%b udr=%b, required 1/0000/0/1/0/0/0",
                     started, neo, busy, wr_if.empty_flg, wr_if.full_flg, ovf_flg, udr_flg);
        end
        check_stats();
        tx_enable = 1'b0;
        @(negedge clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        pq_ch.delete(); pq_start.delete(); pq_len.delete();
        push_word(mkword(1'b1, 0, 24'($urandom)));
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_800k();
        test_400k();
        test_multi_channel();
        test_underrun();
        test_overflow();
        test_enable_drop();
        test_random();
        test_reset_mid_bit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
